// File: rtl/pipeline_pkg.sv
// Shared definitions for the execute stage: bundle field positions, opcode bits, FSM states.
package pipeline_pkg;

    localparam int ID_EX_W  = 161;
    localparam int EX_WB_W  = 100;

    localparam int ID_PC_LSB   = 0;
    localparam int ID_PC_MSB   = 31;
    localparam int ID_OP1_LSB  = 32;
    localparam int ID_OP1_MSB  = 63;
    localparam int ID_OP2_LSB  = 64;
    localparam int ID_OP2_MSB  = 95;
    localparam int ID_RD_LSB   = 96;
    localparam int ID_RD_MSB   = 100;
    localparam int ID_OFF_LSB  = 101;
    localparam int ID_OFF_MSB  = 111;
    localparam int ID_OPC_LSB  = 112;
    localparam int ID_OPC_MSB  = 127;
    localparam int ID_IMM_LSB  = 128;
    localparam int ID_IMM_MSB  = 159;

    localparam int WB_RESULT_LSB = 0;
    localparam int WB_RESULT_MSB = 31;
    localparam int WB_TARGET_LSB = 32;
    localparam int WB_TARGET_MSB = 63;
    localparam int WB_HALT       = 64;
    localparam int WB_BR         = 65;
    localparam int WB_WE         = 66;
    localparam int WB_RD_LSB     = 67;
    localparam int WB_RD_MSB     = 71;

    localparam int OP_ADD  = 0;
    localparam int OP_SUB  = 1;
    localparam int OP_LI   = 2;
    localparam int OP_SHL  = 3;
    localparam int OP_SHR  = 4;
    localparam int OP_AND  = 5;
    localparam int OP_OR   = 6;
    localparam int OP_XOR  = 7;
    localparam int OP_BEQ  = 8;
    localparam int OP_BNE  = 9;
    localparam int OP_MOVE = 10;
    localparam int OP_ADDI = 11;
    localparam int OP_MUL  = 12;
    localparam int OP_HALT = 13;
    localparam int OP_NOP  = 14;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MUL    = 2'd1,
        ST_HALTED = 2'd2
    } ex_state_t;

    function automatic logic is_onehot16(input logic [15:0] v);
        return (v != 16'd0) && ((v & (v - 16'd1)) == 16'd0);
    endfunction

endpackage

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low DATA_W bits of the product.
module seq_multiplier #(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] multiplicand,
    input  logic [DATA_W-1:0] multiplier,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    logic [DATA_W-1:0] mcand_p0;
    logic [DATA_W-1:0] mplier_p0;
    logic [DATA_W-1:0] acc_p0;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  iter_p0;

    // done is combinational so the caller can register the final sum on the last iteration edge
    assign acc_next = mplier_p0[0] ? (acc_p0 + mcand_p0) : acc_p0;
    assign done     = busy && (iter_p0 == CNT_W'(MUL_CYCLES - 1));
    assign product  = acc_next;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            iter_p0   <= '0;
            mcand_p0  <= '0;
            mplier_p0 <= '0;
            acc_p0    <= '0;
        end else if (start && !busy) begin
            busy      <= 1'b1;
            iter_p0   <= '0;
            mcand_p0  <= multiplicand;
            mplier_p0 <= multiplier;
            acc_p0    <= '0;
        end else if (busy) begin
            acc_p0    <= acc_next;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            iter_p0   <= iter_p0 + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, iterative multiply with upstream stall,
// branch resolution with shadow squash, and sticky halt.
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int MUL_CYCLES    = 32,
    parameter int BRANCH_SHADOW = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               id_valid,
    input  logic [ID_EX_W-1:0] ID_EX,
    output logic               stall,
    output logic [EX_WB_W-1:0] EX_WB
);
    localparam int SH_W = (BRANCH_SHADOW > 0) ? $clog2(BRANCH_SHADOW + 1) : 1;

    ex_state_t          state;
    logic [SH_W-1:0]    shadow;
    logic [4:0]         mul_rd;
    logic [EX_WB_W-1:0] wb_p1;

    logic [DATA_W-1:0]        pc, op1, op2, imm32, target, alu_res, mul_product;
    logic [4:0]               rd;
    logic [15:0]              opc;
    logic signed [10:0]       off_s;
    logic signed [DATA_W-1:0] off_sx;
    logic                     legal, alu_we, is_mul, is_halt, taken, is_branch;
    logic                     accept, mul_busy, mul_done;
    logic                     unused_bits;

    assign pc     = ID_EX[ID_PC_MSB:ID_PC_LSB];
    assign op1    = ID_EX[ID_OP1_MSB:ID_OP1_LSB];
    assign op2    = ID_EX[ID_OP2_MSB:ID_OP2_LSB];
    assign rd     = ID_EX[ID_RD_MSB:ID_RD_LSB];
    assign off_s  = ID_EX[ID_OFF_MSB:ID_OFF_LSB];
    assign opc    = ID_EX[ID_OPC_MSB:ID_OPC_LSB];
    assign imm32  = ID_EX[ID_IMM_MSB:ID_IMM_LSB];
    assign unused_bits = ID_EX[ID_EX_W-1];

    assign off_sx = DATA_W'(off_s);
    assign target = pc + $unsigned(off_sx);

    // zero or multi-hot opcode fields fall through as NOP
    assign legal     = is_onehot16(opc);
    assign is_mul    = legal && opc[OP_MUL];
    assign is_halt   = legal && opc[OP_HALT];
    assign is_branch = legal && (opc[OP_BEQ] || opc[OP_BNE]);
    assign taken     = legal && ((opc[OP_BEQ] && (op1 == op2)) || (opc[OP_BNE] && (op1 != op2)));
    assign accept    = id_valid && (state == ST_RUN) && (shadow == '0);

    always_comb begin
        alu_res = '0;
        alu_we  = 1'b0;
        if (legal) begin
            alu_we = 1'b1;
            if      (opc[OP_ADD])  alu_res = op1 + op2;
            else if (opc[OP_SUB])  alu_res = op1 - op2;
            else if (opc[OP_LI])   alu_res = imm32;
            else if (opc[OP_SHL])  alu_res = op1 << op2[4:0];
            else if (opc[OP_SHR])  alu_res = op1 >> op2[4:0];
            else if (opc[OP_AND])  alu_res = op1 & op2;
            else if (opc[OP_OR])   alu_res = op1 | op2;
            else if (opc[OP_XOR])  alu_res = op1 ^ op2;
            else if (opc[OP_MOVE]) alu_res = op1;
            else if (opc[OP_ADDI]) alu_res = op1 + imm32;
            else                   alu_we  = 1'b0;
        end
    end

    seq_multiplier #(
        .DATA_W    (DATA_W),
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (accept && is_mul),
        .multiplicand(op1),
        .multiplier  (op2),
        .busy        (mul_busy),
        .done        (mul_done),
        .product     (mul_product)
    );

    assign stall = mul_busy;
    assign EX_WB = wb_p1;

    // p1: registered EX_WB bundle; we/br are pulses, halt is sticky until reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state  <= ST_RUN;
            shadow <= '0;
            mul_rd <= '0;
            wb_p1  <= '0;
        end else begin
            wb_p1[WB_WE] <= 1'b0;
            wb_p1[WB_BR] <= 1'b0;
            unique case (state)
                ST_RUN: begin
                    wb_p1[WB_TARGET_MSB:WB_TARGET_LSB] <= '0;
                    if (id_valid && (shadow != '0)) begin
                        shadow <= shadow - 1'b1;
                    end else if (accept) begin
                        wb_p1[WB_RD_MSB:WB_RD_LSB] <= rd;
                        if (is_mul) begin
                            mul_rd <= rd;
                            state  <= ST_MUL;
                        end else if (is_halt) begin
                            wb_p1[WB_HALT] <= 1'b1;
                            state          <= ST_HALTED;
                        end else if (is_branch) begin
                            if (taken) begin
                                wb_p1[WB_BR] <= 1'b1;
                                wb_p1[WB_TARGET_MSB:WB_TARGET_LSB] <= target;
                                shadow <= SH_W'(BRANCH_SHADOW);
                            end
                        end else if (alu_we) begin
                            wb_p1[WB_WE] <= 1'b1;
                            wb_p1[WB_RESULT_MSB:WB_RESULT_LSB] <= alu_res;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        wb_p1[WB_WE] <= 1'b1;
                        wb_p1[WB_RESULT_MSB:WB_RESULT_LSB] <= mul_product;
                        wb_p1[WB_RD_MSB:WB_RD_LSB] <= mul_rd;
                        state <= ST_RUN;
                    end
                end
                ST_HALTED: begin
                    state <= ST_HALTED;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule
